// File: rtl/mcpu_pkg.sv
// Purpose: shared encodings for the multi-cycle CPU: FSM states, opcodes, functs, ALU control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mcpu_if.sv
// Purpose: instruction + data memory request bundle between the CPU (master) and memories (slave).
// Latency: n/a (wires only).
// Backpressure: each request is held by the master until the matching *_ready is seen high.
interface mcpu_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mcpu_alu.sv
// Purpose: 32-bit combinational ALU (add/sub wrap modulo 2^32, and, or, signed set-less-than).
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: a, b operands; ctrl operation select; y result.
module mcpu_alu
  import mcpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_t   ctrl,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/regfile.sv
// Purpose: 32x32 register file, two async read ports, one sync write port; register 0 is hardwired to 0.
// Latency: reads 0 cycles, write visible after the clock edge.
// Backpressure: none. Contents are intentionally not reset.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b read ports.
module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];
endmodule

// File: rtl/mcpu_core.sv
// Purpose: multi-cycle MIPS-subset CPU (FETCH/DECODE/EXEC/MEM/WB); optional BNE via `ifdef MCPU_BNE_EN.
// Latency: zero-wait memory: BEQ/J 3 cycles, R-type/ADDI/SW 4, LW 5; each memory wait adds a cycle.
// Backpressure: FETCH and MEM stall, holding address/data, until imem_ready / dmem_ready.
// Ports: clk, reset (sync, active-high); bus (mcpu_if.master: imem_* fetch, dmem_* data); state_o debug state.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       reset,
  mcpu_if.master     bus,
  output logic [2:0] state_o
);
  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a_reg, b_reg, alu_out, mdr;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [25:0] target;
  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign target   = ir[25:0];
  assign imm_sext = sext16(ir[15:0]);

  logic is_rtype, is_alu_op, is_mem_op, is_j, take_br;
  always_comb begin
    is_rtype  = (op == OP_RTYPE) &&
                (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    is_alu_op = is_rtype || (op == OP_ADDI);
    is_mem_op = (op == OP_LW) || (op == OP_SW);
    is_j      = (op == OP_J);
`ifdef MCPU_BNE_EN
    take_br   = ((op == OP_BEQ) && (a_reg == b_reg)) ||
                ((op == OP_BNE) && (a_reg != b_reg));
`else
    take_br   = (op == OP_BEQ) && (a_reg == b_reg);
`endif
  end

  // ALU: R-type uses B and funct; ADDI/LW/SW add the sign-extended immediate.
  alu_ctrl_t   alu_ctrl;
  logic [31:0] alu_b, alu_y;
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end
  assign alu_b = (op == OP_RTYPE) ? b_reg : imm_sext;

  mcpu_alu u_alu (.a(a_reg), .b(alu_b), .ctrl(alu_ctrl), .y(alu_y));

  // Write is gated by reset so a reset edge landing in WB commits nothing.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rf_rdata_a, rf_rdata_b;
  assign rf_we    = (state == WB) && !reset;
  assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

  regfile u_rf (
    .clk(clk), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(rf_rdata_a), .rdata_b(rf_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) next_state = DECODE;
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        if (is_alu_op)      next_state = WB;
        else if (is_mem_op) next_state = MEM;
        else                next_state = FETCH;  // branches, jump, NOPs
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) next_state = (op == OP_SW) ? FETCH : WB;
      end
      WB:      next_state = FETCH;
      default: next_state = FETCH;
    endcase
    if (reset) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: if (bus.imem_ready) begin
          ir <= bus.imem_rdata;
          pc <= pc + ADDR_W'(4);
        end
        DECODE: begin
          a_reg <= rf_rdata_a;
          b_reg <= rf_rdata_b;
        end
        EXEC: begin
          if (is_alu_op || is_mem_op) alu_out <= alu_y;
          // pc already points past the branch, so the offset is relative to PC+4.
          if (take_br) pc <= pc + ADDR_W'(imm_sext << 2);
          if (is_j)    pc <= {pc[ADDR_W-1:28], target, 2'b00};
        end
        MEM: if (bus.dmem_ready && (op == OP_LW)) mdr <= bus.dmem_rdata;
        default: ;
      endcase
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = ADDR_W'(alu_out);
  assign bus.dmem_wdata = b_reg;
  assign bus.dmem_we    = (op == OP_SW);
  assign state_o        = state;
endmodule

// File: tb/tb_mcpu_core.sv
// Purpose: directed self-checking bench for mcpu_core with a behavioural instruction/data memory.
// Latency: n/a.
// Backpressure: data memory ready can be delayed by dmem_dly cycles per access.
module tb_mcpu_core;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_o;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  mcpu_if #(.ADDR_W(32)) bus ();

  mcpu_core #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(state_o)
  );

  // Behavioural memories.
  logic [31:0] imem [128];
  logic [31:0] dmem [16];
  int          dmem_dly = 0;
  int          wcnt = 0;

  assign bus.imem_rdata = imem[bus.imem_addr[8:2]];
  assign bus.imem_ready = 1'b1;
  assign bus.dmem_rdata = dmem[bus.dmem_addr[5:2]];
  assign bus.dmem_ready = bus.dmem_req && (wcnt == dmem_dly);

  always @(posedge clk) begin
    if (bus.dmem_req && !bus.dmem_ready) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
    if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
      dmem[bus.dmem_addr[5:2]] = bus.dmem_wdata;
  end

  // Bus protocol monitor.
  logic        overlap = 1'b0, unstable = 1'b0;
  logic        prev_req = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0, last_daddr = '0;
  int          mem_cyc = 0;
  always @(negedge clk) begin
    if (bus.imem_req && bus.dmem_req) overlap = 1'b1;
    if (prev_req && !prev_rdy && bus.dmem_req &&
        (bus.dmem_addr != prev_addr || bus.dmem_wdata != prev_wdata || bus.dmem_we != prev_we))
      unstable = 1'b1;
    if (bus.dmem_req) begin
      last_daddr = bus.dmem_addr;
      mem_cyc++;
    end
    prev_req   = bus.dmem_req;
    prev_rdy   = bus.dmem_ready;
    prev_we    = bus.dmem_we;
    prev_addr  = bus.dmem_addr;
    prev_wdata = bus.dmem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Runs one instruction: ticks until the FSM is back in FETCH, bounded.
  task automatic run_instr(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (state_o != 3'd0 && n < 50);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  int n;
  int cyc;
  logic [31:0] exp_bne;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    clear_imem();
    imem[0] = 32'h2001_0005;  // ADDI $1,$0,5
    imem[1] = 32'h2002_FFFD;  // ADDI $2,$0,-3
    imem[2] = 32'h0022_1820;  // ADD  $3,$1,$2
    imem[3] = 32'h0041_202A;  // SLT  $4,$2,$1
    imem[4] = 32'h0041_3822;  // SUB  $7,$2,$1
    imem[5] = 32'hAC01_0008;  // SW   $1,8($0)
    imem[6] = 32'h8C05_0008;  // LW   $5,8($0)

    // Reset behaviour.
    tick();
    tick();
    chk("rst_state", {29'b0, state_o}, 32'd0);
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_imem_req", {31'b0, bus.imem_req}, 32'd1);
    chk("post_rst_pc", bus.imem_addr, 32'h0);

    // ADDI, ADDI, ADD: 12 cycles total.
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      run_instr(n);
      cyc += n;
    end
    chk("seq3_cycles", cyc, 32'd12);
    chk("r1_addi", dut.u_rf.regs[1], 32'd5);
    chk("r2_addi_neg", dut.u_rf.regs[2], 32'hFFFF_FFFD);
    chk("r3_add", dut.u_rf.regs[3], 32'd2);
    chk("pc_after_seq3", bus.imem_addr, 32'h0C);

    run_instr(n);
    chk("slt_cycles", n, 32'd4);
    chk("r4_slt", dut.u_rf.regs[4], 32'd1);
    run_instr(n);
    chk("r7_sub", dut.u_rf.regs[7], 32'hFFFF_FFF8);

    // SW / LW with three wait cycles on the data port.
    dmem_dly = 3;
    mem_cyc  = 0;
    run_instr(n);
    chk("sw_cycles", n, 32'd7);
    chk("sw_mem_cycles", mem_cyc, 32'd4);
    chk("sw_addr", last_daddr, 32'd8);
    chk("sw_dmem", dmem[2], 32'd5);
    mem_cyc = 0;
    run_instr(n);
    chk("lw_cycles", n, 32'd8);
    chk("lw_mem_cycles", mem_cyc, 32'd4);
    chk("lw_addr", last_daddr, 32'd8);
    chk("r5_lw", dut.u_rf.regs[5], 32'd5);

    // J to 0x10 then BEQ $0,$0,-1 loops onto itself.
    dmem_dly = 0;
    clear_imem();
    imem[0] = 32'h0800_0004;  // J 0x4 -> 0x10
    imem[4] = 32'h1000_FFFF;  // BEQ $0,$0,-1
    do_reset();
    run_instr(n);
    chk("j_cycles", n, 32'd3);
    chk("j_to_10", bus.imem_addr, 32'h10);
    run_instr(n);
    chk("beq_cycles", n, 32'd3);
    chk("beq_taken_pc", bus.imem_addr, 32'h10);

    // J 0x40, untaken BEQ, opcode 0x05, unsupported funct.
    clear_imem();
    imem[0]  = 32'h0800_0040;  // J 0x40 -> 0x100
    imem[64] = 32'h1022_0003;  // BEQ $1,$2,3 (5 != -3)
    imem[65] = 32'h1422_0002;  // opcode 0x05 $1,$2,2
    imem[66] = 32'h0022_183F;  // R-type funct 0x3F -> NOP
    imem[68] = 32'h0022_183F;
    do_reset();
    run_instr(n);
    chk("j_to_100", bus.imem_addr, 32'h100);
    run_instr(n);
    chk("beq_not_taken_pc", bus.imem_addr, 32'h104);
`ifdef MCPU_BNE_EN
    exp_bne = 32'h110;
`else
    exp_bne = 32'h108;
`endif
    run_instr(n);
    chk("op05_cycles", n, 32'd3);
    chk("op05_pc", bus.imem_addr, exp_bne);
    run_instr(n);
    chk("nop_cycles", n, 32'd3);
    chk("nop_r3_kept", dut.u_rf.regs[3], 32'd2);
    chk("nop_pc", bus.imem_addr, exp_bne + 32'd4);

    // Reset during the MEM wait of an LW.
    dmem_dly = 3;
    dmem[3]  = 32'hDEAD_BEEF;
    clear_imem();
    imem[0] = 32'h8C05_000C;  // LW $5,12($0)
    do_reset();
    tick();
    tick();
    tick();
    chk("lw_in_mem", {29'b0, state_o}, 32'd3);
    chk("lw_wait_addr", bus.dmem_addr, 32'hC);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_mid_imem_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_state", {29'b0, state_o}, 32'd0);
    chk("rst_mid_pc", bus.imem_addr, 32'h0);
    chk("rst_mid_r5_kept", dut.u_rf.regs[5], 32'd5);
    chk("rst_mid_fetch_req", {31'b0, bus.imem_req}, 32'd1);

    // Whole-run bus protocol properties.
    chk("no_req_overlap", {31'b0, overlap}, 32'd0);
    chk("dmem_stable", {31'b0, unstable}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
